// File: rtl/ldpc_ber_regmap_pkg.sv
// Shared constants for the multi-channel LDPC BER tester register map:
// identification words, global register addresses and per-channel window offsets.
package ldpc_ber_regmap_pkg;

    localparam logic [31:0] CORE_VERSION = 32'h0002_0061;
    localparam logic [31:0] CORE_MAGIC   = 32'h4350_444C;

    localparam int REG_VERSION   = 'h00;
    localparam int REG_ID        = 'h01;
    localparam int REG_SCRATCH   = 'h02;
    localparam int REG_MAGIC     = 'h03;
    localparam int REG_CONFIG    = 'h04;
    localparam int REG_GLOBAL_EN = 'h06;

    localparam int CH_BASE   = 'h100;
    localparam int CH_STRIDE = 'h20;

    // Word offsets inside one channel window.
    localparam logic [4:0] OFF_CTRL      = 5'h00;
    localparam logic [4:0] OFF_AWGN      = 5'h01;
    localparam logic [4:0] OFF_CTRL_WORD = 5'h02;
    localparam logic [4:0] OFF_MASK0     = 5'h04;
    localparam logic [4:0] OFF_FB_LO     = 5'h10;
    localparam logic [4:0] OFF_FB_HI     = 5'h11;
    localparam logic [4:0] OFF_BER       = 5'h12;

    function automatic logic [4:0] mask_offset(input int k);
        return 5'(int'(OFF_MASK0) + k);
    endfunction

endpackage

// File: rtl/ldpc_ber_regmap_ch.sv
// One channel's register bank: config registers, soft-reset pulse counter,
// counter shadow latch, local write decode and read mux.
module ldpc_ber_regmap_ch
    import ldpc_ber_regmap_pkg::*;
#(
    parameter int MASK_WIDTH      = 128,
    parameter int RESET_PULSE_LEN = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_sel_i,
    input  logic [4:0]            wr_off_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  rd_sel_i,
    input  logic [4:0]            rd_off_i,
    input  logic                  global_en_i,
    input  logic [63:0]           finished_blocks_i,
    input  logic [31:0]           bit_errors_i,
    output logic                  ch_en_o,
    output logic                  sw_resetn_o,
    output logic [15:0]           factor_o,
    output logic [7:0]            offset_o,
    output logic [31:0]           ctrl_word_o,
    output logic [MASK_WIDTH-1:0] last_mask_o,
    output logic [31:0]           rd_data_o
);

    localparam int MASK_WORDS = MASK_WIDTH / 32;

    logic                  en_q, en_d;
    logic [15:0]           factor_q, factor_d;
    logic [7:0]            offset_q, offset_d;
    logic [31:0]           ctrl_word_q, ctrl_word_d;
    logic [MASK_WIDTH-1:0] mask_q, mask_d;
    logic [7:0]            pulse_cnt_q, pulse_cnt_d;
    logic [31:0]           sh_hi_q, sh_hi_d;
    logic [31:0]           sh_be_q, sh_be_d;
    logic                  ch_en_q;
    logic                  sw_resetn_q;

    always_comb begin
        en_d        = en_q;
        factor_d    = factor_q;
        offset_d    = offset_q;
        ctrl_word_d = ctrl_word_q;
        mask_d      = mask_q;
        pulse_cnt_d = pulse_cnt_q;
        sh_hi_d     = sh_hi_q;
        sh_be_d     = sh_be_q;

        if (wr_sel_i) begin
            case (wr_off_i)
                OFF_CTRL:      en_d = wr_data_i[0];
                OFF_AWGN: begin
                    factor_d = wr_data_i[15:0];
                    offset_d = wr_data_i[23:16];
                end
                OFF_CTRL_WORD: ctrl_word_d = wr_data_i;
                default: ;
            endcase
            for (int k = 0; k < MASK_WORDS; k++) begin
                if (wr_off_i == mask_offset(k)) mask_d[32*k +: 32] = wr_data_i;
            end
        end

        // A new request reloads the counter, so repeated requests stretch the pulse.
        if (wr_sel_i && wr_off_i == OFF_CTRL && wr_data_i[1]) begin
            pulse_cnt_d = 8'(RESET_PULSE_LEN);
        end else if (pulse_cnt_q != 8'd0) begin
            pulse_cnt_d = pulse_cnt_q - 8'd1;
        end

        // Reading the low half freezes the high half and the error count together.
        if (rd_sel_i && rd_off_i == OFF_FB_LO) begin
            sh_hi_d = finished_blocks_i[63:32];
            sh_be_d = bit_errors_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q        <= 1'b0;
            factor_q    <= '0;
            offset_q    <= '0;
            ctrl_word_q <= '0;
            mask_q      <= '0;
            pulse_cnt_q <= '0;
            sh_hi_q     <= '0;
            sh_be_q     <= '0;
            ch_en_q     <= 1'b0;
            sw_resetn_q <= 1'b0;
        end else begin
            en_q        <= en_d;
            factor_q    <= factor_d;
            offset_q    <= offset_d;
            ctrl_word_q <= ctrl_word_d;
            mask_q      <= mask_d;
            pulse_cnt_q <= pulse_cnt_d;
            sh_hi_q     <= sh_hi_d;
            sh_be_q     <= sh_be_d;
            ch_en_q     <= en_q & global_en_i;
            sw_resetn_q <= (pulse_cnt_d == 8'd0);
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_sel_i) begin
            case (rd_off_i)
                OFF_CTRL:      rd_data_o = {30'd0, pulse_cnt_q != 8'd0, en_q};
                OFF_AWGN:      rd_data_o = {8'h00, offset_q, factor_q};
                OFF_CTRL_WORD: rd_data_o = ctrl_word_q;
                OFF_FB_LO:     rd_data_o = finished_blocks_i[31:0];
                OFF_FB_HI:     rd_data_o = sh_hi_q;
                OFF_BER:       rd_data_o = sh_be_q;
                default: ;
            endcase
            for (int k = 0; k < MASK_WORDS; k++) begin
                if (rd_off_i == mask_offset(k)) rd_data_o = mask_q[32*k +: 32];
            end
        end
    end

    assign ch_en_o     = ch_en_q;
    assign sw_resetn_o = sw_resetn_q;
    assign factor_o    = factor_q;
    assign offset_o    = offset_q;
    assign ctrl_word_o = ctrl_word_q;
    assign last_mask_o = mask_q;

endmodule

// File: rtl/ldpc_ber_regmap_mc.sv
// Multi-channel register map for the LDPC BER tester: global registers,
// per-channel window decode and one register bank per channel.
module ldpc_ber_regmap_mc
    import ldpc_ber_regmap_pkg::*;
#(
    parameter int          NUM_CH          = 4,
    parameter int          ADDRESS_WIDTH   = 10,
    parameter int          MASK_WIDTH      = 128,
    parameter logic [31:0] SEED_ID         = 32'd0,
    parameter int          RESET_PULSE_LEN = 4
) (
    input  logic                         up_clk,
    input  logic                         up_resetn,
    input  logic                         up_rreq,
    output logic                         up_rack,
    input  logic [ADDRESS_WIDTH-1:0]     up_raddr,
    output logic [31:0]                  up_rdata,
    input  logic                         up_wreq,
    output logic                         up_wack,
    input  logic [ADDRESS_WIDTH-1:0]     up_waddr,
    input  logic [31:0]                  up_wdata,
    output logic [NUM_CH-1:0]            ch_en,
    output logic [NUM_CH-1:0]            ch_sw_resetn,
    output logic [16*NUM_CH-1:0]         ch_factor,
    output logic [8*NUM_CH-1:0]          ch_offset,
    output logic [32*NUM_CH-1:0]         ch_ctrl_word,
    output logic [MASK_WIDTH*NUM_CH-1:0] ch_last_mask,
    input  logic [64*NUM_CH-1:0]         ch_finished_blocks,
    input  logic [32*NUM_CH-1:0]         ch_bit_errors
);

    localparam int MASK_WORDS = MASK_WIDTH / 32;
    localparam logic [ADDRESS_WIDTH-1:0] CH_BASE_A = ADDRESS_WIDTH'(CH_BASE);
    localparam logic [31:0] CONFIG_WORD = {8'(ADDRESS_WIDTH), 8'(MASK_WORDS), 16'(NUM_CH)};

    logic                     rd_win, wr_win;
    logic [ADDRESS_WIDTH-1:0] raddr_rel, waddr_rel;
    logic [31:0]              ch_rdata [NUM_CH];
    logic [31:0]              ch_rdata_or;
    logic [31:0]              glob_rdata;
    logic [31:0]              scratch_q, scratch_d;
    logic                     gen_q, gen_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     rack_q, wack_q;

    // Anything below the first channel base belongs to the global map.
    assign rd_win    = (up_raddr >= CH_BASE_A);
    assign wr_win    = (up_waddr >= CH_BASE_A);
    assign raddr_rel = up_raddr - CH_BASE_A;
    assign waddr_rel = up_waddr - CH_BASE_A;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic rd_hit, wr_hit;

        assign rd_hit = up_rreq && rd_win && ((int'(raddr_rel) / CH_STRIDE) == c);
        assign wr_hit = up_wreq && wr_win && ((int'(waddr_rel) / CH_STRIDE) == c);

        ldpc_ber_regmap_ch #(
            .MASK_WIDTH      (MASK_WIDTH),
            .RESET_PULSE_LEN (RESET_PULSE_LEN)
        ) u_ch (
            .clk_i             (up_clk),
            .rst_n_i           (up_resetn),
            .wr_sel_i          (wr_hit),
            .wr_off_i          (waddr_rel[4:0]),
            .wr_data_i         (up_wdata),
            .rd_sel_i          (rd_hit),
            .rd_off_i          (raddr_rel[4:0]),
            .global_en_i       (gen_q),
            .finished_blocks_i (ch_finished_blocks[64*c +: 64]),
            .bit_errors_i      (ch_bit_errors[32*c +: 32]),
            .ch_en_o           (ch_en[c]),
            .sw_resetn_o       (ch_sw_resetn[c]),
            .factor_o          (ch_factor[16*c +: 16]),
            .offset_o          (ch_offset[8*c +: 8]),
            .ctrl_word_o       (ch_ctrl_word[32*c +: 32]),
            .last_mask_o       (ch_last_mask[MASK_WIDTH*c +: MASK_WIDTH]),
            .rd_data_o         (ch_rdata[c])
        );
    end

    // Unselected banks drive zero, so a plain OR merges the channel read data.
    always_comb begin
        ch_rdata_or = '0;
        for (int c = 0; c < NUM_CH; c++) ch_rdata_or = ch_rdata_or | ch_rdata[c];
    end

    always_comb begin
        glob_rdata = '0;
        if (!rd_win) begin
            case (up_raddr)
                ADDRESS_WIDTH'(REG_VERSION):   glob_rdata = CORE_VERSION;
                ADDRESS_WIDTH'(REG_ID):        glob_rdata = SEED_ID;
                ADDRESS_WIDTH'(REG_SCRATCH):   glob_rdata = scratch_q;
                ADDRESS_WIDTH'(REG_MAGIC):     glob_rdata = CORE_MAGIC;
                ADDRESS_WIDTH'(REG_CONFIG):    glob_rdata = CONFIG_WORD;
                ADDRESS_WIDTH'(REG_GLOBAL_EN): glob_rdata = {31'd0, gen_q};
                default: ;
            endcase
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        gen_d     = gen_q;
        rdata_d   = rdata_q;
        if (up_wreq && !wr_win) begin
            if (up_waddr == ADDRESS_WIDTH'(REG_SCRATCH))   scratch_d = up_wdata;
            if (up_waddr == ADDRESS_WIDTH'(REG_GLOBAL_EN)) gen_d     = up_wdata[0];
        end
        if (up_rreq) rdata_d = glob_rdata | ch_rdata_or;
    end

    always_ff @(posedge up_clk or negedge up_resetn) begin
        if (!up_resetn) begin
            scratch_q <= '0;
            gen_q     <= 1'b0;
            rdata_q   <= '0;
            rack_q    <= 1'b0;
            wack_q    <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            gen_q     <= gen_d;
            rdata_q   <= rdata_d;
            rack_q    <= up_rreq;
            wack_q    <= up_wreq;
        end
    end

    assign up_rdata = rdata_q;
    assign up_rack  = rack_q;
    assign up_wack  = wack_q;

endmodule

// File: tb/tb_ldpc_ber_regmap_mc.sv
// Self-checking bench for ldpc_ber_regmap_mc: directed register scenarios plus
// randomized traffic compared every cycle against a behavioural register-map model.
module tb_ldpc_ber_regmap_mc;

    localparam int NUM_CH = 4;
    localparam int AW     = 10;
    localparam int MW     = 128;
    localparam int MWORDS = MW / 32;
    localparam int PLEN   = 4;
    localparam logic [31:0] SEED = 32'd0;

    logic                   up_clk = 1'b0;
    logic                   up_resetn = 1'b1;
    logic                   up_rreq = 1'b0;
    logic                   up_rack;
    logic [AW-1:0]          up_raddr = '0;
    logic [31:0]            up_rdata;
    logic                   up_wreq = 1'b0;
    logic                   up_wack;
    logic [AW-1:0]          up_waddr = '0;
    logic [31:0]            up_wdata = '0;
    logic [NUM_CH-1:0]      ch_en;
    logic [NUM_CH-1:0]      ch_sw_resetn;
    logic [16*NUM_CH-1:0]   ch_factor;
    logic [8*NUM_CH-1:0]    ch_offset;
    logic [32*NUM_CH-1:0]   ch_ctrl_word;
    logic [MW*NUM_CH-1:0]   ch_last_mask;
    logic [64*NUM_CH-1:0]   ch_finished_blocks = '0;
    logic [32*NUM_CH-1:0]   ch_bit_errors = '0;

    always #5 up_clk = ~up_clk;

    ldpc_ber_regmap_mc #(
        .NUM_CH          (NUM_CH),
        .ADDRESS_WIDTH   (AW),
        .MASK_WIDTH      (MW),
        .SEED_ID         (SEED),
        .RESET_PULSE_LEN (PLEN)
    ) dut (
        .up_clk             (up_clk),
        .up_resetn          (up_resetn),
        .up_rreq            (up_rreq),
        .up_rack            (up_rack),
        .up_raddr           (up_raddr),
        .up_rdata           (up_rdata),
        .up_wreq            (up_wreq),
        .up_wack            (up_wack),
        .up_waddr           (up_waddr),
        .up_wdata           (up_wdata),
        .ch_en              (ch_en),
        .ch_sw_resetn       (ch_sw_resetn),
        .ch_factor          (ch_factor),
        .ch_offset          (ch_offset),
        .ch_ctrl_word       (ch_ctrl_word),
        .ch_last_mask       (ch_last_mask),
        .ch_finished_blocks (ch_finished_blocks),
        .ch_bit_errors      (ch_bit_errors)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint      cyc;
    logic [31:0] m_scratch;
    logic        m_gen;
    logic        m_en     [NUM_CH];
    logic [15:0] m_factor [NUM_CH];
    logic [7:0]  m_offset [NUM_CH];
    logic [31:0] m_cw     [NUM_CH];
    logic [31:0] m_mask   [NUM_CH][MWORDS];
    longint      pulse_end[NUM_CH];
    logic [31:0] m_sh_hi  [NUM_CH];
    logic [31:0] m_sh_be  [NUM_CH];
    logic              exp_rack, exp_wack;
    logic [31:0]       exp_rdata;
    logic [NUM_CH-1:0] exp_en, exp_resetn;

    function automatic void model_reset();
        cyc = 0; m_scratch = '0; m_gen = 1'b0;
        exp_rack = 1'b0; exp_wack = 1'b0; exp_rdata = '0; exp_en = '0; exp_resetn = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_en[c] = 1'b0; m_factor[c] = '0; m_offset[c] = '0; m_cw[c] = '0;
            pulse_end[c] = 0; m_sh_hi[c] = '0; m_sh_be[c] = '0;
            for (int k = 0; k < MWORDS; k++) m_mask[c][k] = '0;
        end
    endfunction

    // Pulse is "active" for a read at edge cyc if the state just before that edge was inside the pulse.
    function automatic logic [31:0] model_read(input int unsigned a);
        int unsigned c, off;
        if (a < 'h100) begin
            case (a)
                0: return 32'h0002_0061;
                1: return SEED;
                2: return m_scratch;
                3: return 32'h4350_444C;
                4: return {8'(AW), 8'(MWORDS), 16'(NUM_CH)};
                6: return {31'd0, m_gen};
                default: return 32'd0;
            endcase
        end
        c = (a - 'h100) / 32;
        off = (a - 'h100) % 32;
        if (c >= NUM_CH) return 32'd0;
        if (off == 0) return {30'd0, (cyc - 1) < pulse_end[c], m_en[c]};
        if (off == 1) return {8'h00, m_offset[c], m_factor[c]};
        if (off == 2) return m_cw[c];
        if (off >= 4 && off < 4 + MWORDS) return m_mask[c][off-4];
        if (off == 'h10) return ch_finished_blocks[64*c +: 32];
        if (off == 'h11) return m_sh_hi[c];
        if (off == 'h12) return m_sh_be[c];
        return 32'd0;
    endfunction

    function automatic void model_shadow(input int unsigned a);
        int unsigned c;
        if (a < 'h100) return;
        c = (a - 'h100) / 32;
        if (c < NUM_CH && (a - 'h100) % 32 == 'h10) begin
            m_sh_hi[c] = ch_finished_blocks[64*c+32 +: 32];
            m_sh_be[c] = ch_bit_errors[32*c +: 32];
        end
    endfunction

    function automatic void model_write(input int unsigned a, input logic [31:0] d);
        int unsigned c, off;
        if (a < 'h100) begin
            if (a == 2) m_scratch = d;
            if (a == 6) m_gen = d[0];
            return;
        end
        c = (a - 'h100) / 32;
        off = (a - 'h100) % 32;
        if (c >= NUM_CH) return;
        if (off == 0) begin
            m_en[c] = d[0];
            if (d[1]) pulse_end[c] = cyc + PLEN;
        end else if (off == 1) begin
            m_factor[c] = d[15:0];
            m_offset[c] = d[23:16];
        end else if (off == 2) begin
            m_cw[c] = d;
        end else if (off >= 4 && off < 4 + MWORDS) begin
            m_mask[c][off-4] = d;
        end
    endfunction

    initial model_reset();

    always @(posedge up_clk or negedge up_resetn) begin
        if (!up_resetn) begin
            model_reset();
        end else begin
            cyc++;
            exp_wack = up_wreq;
            exp_rack = up_rreq;
            for (int c = 0; c < NUM_CH; c++) exp_en[c] = m_en[c] & m_gen;
            if (up_rreq) begin
                exp_rdata = model_read(int'(up_raddr));
                model_shadow(int'(up_raddr));
            end
            if (up_wreq) model_write(int'(up_waddr), up_wdata);
            for (int c = 0; c < NUM_CH; c++) exp_resetn[c] = !(cyc < pulse_end[c]);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [16*NUM_CH-1:0] e_factor;
    logic [8*NUM_CH-1:0]  e_offset;
    logic [32*NUM_CH-1:0] e_cw;
    logic [MW*NUM_CH-1:0] e_mask;

    always @(negedge up_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            e_factor[16*c +: 16] = m_factor[c];
            e_offset[8*c +: 8]   = m_offset[c];
            e_cw[32*c +: 32]     = m_cw[c];
            for (int k = 0; k < MWORDS; k++) e_mask[MW*c + 32*k +: 32] = m_mask[c][k];
        end
        check("cyc_rack",      512'(up_rack),      512'(exp_rack));
        check("cyc_wack",      512'(up_wack),      512'(exp_wack));
        check("cyc_rdata",     512'(up_rdata),     512'(exp_rdata));
        check("cyc_ch_en",     512'(ch_en),        512'(exp_en));
        check("cyc_sw_resetn", 512'(ch_sw_resetn), 512'(exp_resetn));
        check("cyc_factor",    512'(ch_factor),    512'(e_factor));
        check("cyc_offset",    512'(ch_offset),    512'(e_offset));
        check("cyc_ctrl_word", 512'(ch_ctrl_word), 512'(e_cw));
        check("cyc_last_mask", 512'(ch_last_mask), 512'(e_mask));
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge up_clk);
        up_wreq = 1'b1; up_waddr = a; up_wdata = d;
        @(negedge up_clk);
        up_wreq = 1'b0;
        check("wack_latency", 512'(up_wack), 512'(1));
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d);
        @(negedge up_clk);
        up_rreq = 1'b1; up_raddr = a;
        @(negedge up_clk);
        up_rreq = 1'b0;
        check("rack_latency", 512'(up_rack), 512'(1));
        d = up_rdata;
    endtask

    task automatic read_expect(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, d);
        check(name, 512'(d), 512'(exp));
    endtask

    task automatic count_reset_low(input string name, input int exp);
        int n = 0;
        while (ch_sw_resetn[0] == 1'b0 && n < 20) begin
            n++;
            @(negedge up_clk);
        end
        check(name, 512'(n), 512'(exp));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int sel = $urandom_range(0, 9);
        if (sel < 2) return AW'($urandom_range(0, 7));
        if (sel < 9) return AW'('h100 + 'h20 * $urandom_range(0, NUM_CH) + $urandom_range(0, 19));
        return AW'($urandom_range(0, 1023));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 up_resetn = 1'b0;
        #1;
        check("reset_sw_resetn", 512'(ch_sw_resetn), 512'(0));
        check("reset_rack",      512'(up_rack),      512'(0));
        repeat (3) @(negedge up_clk);
        up_resetn = 1'b1;
        @(negedge up_clk);
        check("first_edge_sw_resetn", 512'(ch_sw_resetn), 512'(4'hF));

        // identification and config registers
        read_expect("rd_version", 'h000, 32'h0002_0061);
        read_expect("rd_magic",   'h003, 32'h4350_444C);
        read_expect("rd_config",  'h004, 32'h0A04_0004); // {AW=0x0A, 4 mask words, 4 channels}
        read_expect("rd_id",      'h001, 32'h0000_0000);
        do_write('h002, 32'hCAFE_F00D);
        read_expect("rd_scratch", 'h002, 32'hCAFE_F00D);

        // AWGN word of channel 0
        do_write('h101, 32'h00AB_1234);
        check("factor_ch0",   512'(ch_factor[15:0]),  512'(16'h1234));
        check("offset_ch0",   512'(ch_offset[7:0]),   512'(8'hAB));
        check("factor_other", 512'(ch_factor[63:16]), 512'(0));
        read_expect("rd_awgn", 'h101, 32'h00AB_1234);

        // independently written mask words
        do_write('h104, 32'hDEAD_BEEF);
        do_write('h107, 32'h1234_5678);
        check("mask_ch0", 512'(ch_last_mask[127:0]), 512'(128'h12345678_00000000_00000000_DEADBEEF));

        // soft-reset pulse and global enable gate
        do_write('h100, 32'h3);
        count_reset_low("pulse_len", PLEN);
        read_expect("rd_ctrl_after", 'h100, 32'h1);
        check("ch_en_gated", 512'(ch_en[0]), 512'(0));
        do_write('h006, 32'h1);
        check("ch_en_lag", 512'(ch_en[0]), 512'(0));
        @(negedge up_clk);
        check("ch_en_on", 512'(ch_en[0]), 512'(1));
        do_write('h100, 32'h3);
        read_expect("rd_ctrl_during", 'h100, 32'h3);
        repeat (6) @(negedge up_clk);
        do_write('h100, 32'h3);
        do_write('h100, 32'h3);
        count_reset_low("pulse_reload", PLEN);

        // shadow latch of the 64-bit counter
        ch_finished_blocks[63:0] = 64'h0000_0001_FFFF_FFFF;
        ch_bit_errors[31:0] = 32'h0000_0055;
        read_expect("rd_fb_lo", 'h110, 32'hFFFF_FFFF);
        ch_finished_blocks[63:0] = 64'h0000_0002_0000_0000;
        ch_bit_errors[31:0] = 32'h0000_0077;
        read_expect("rd_fb_hi_shadow", 'h111, 32'h0000_0001);
        read_expect("rd_ber_shadow",   'h112, 32'h0000_0055);

        // out-of-range channel window and unmapped offsets
        read_expect("rd_unmapped_ch", 'h180, 32'h0);
        do_write('h180, 32'hFFFF_FFFF);
        read_expect("rd_unmapped_off", 'h113, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge up_clk);
            up_rreq  = 1'($urandom_range(0, 1));
            up_raddr = rand_addr();
            up_wreq  = 1'($urandom_range(0, 1));
            up_waddr = ($urandom_range(0, 3) == 0) ? up_raddr : rand_addr();
            up_wdata = $urandom();
            for (int c = 0; c < NUM_CH; c++) begin
                ch_finished_blocks[64*c +: 64] = {$urandom(), $urandom()};
                ch_bit_errors[32*c +: 32] = $urandom();
            end
        end
        @(negedge up_clk);
        up_rreq = 1'b0;
        up_wreq = 1'b0;

        // asynchronous reset in the middle of a pulse
        do_write('h101, 32'h0011_2233);
        do_write('h100, 32'h3);
        #2 up_resetn = 1'b0;
        #1;
        check("async_sw_resetn", 512'(ch_sw_resetn), 512'(0));
        check("async_ch_en",     512'(ch_en),        512'(0));
        check("async_factor",    512'(ch_factor),    512'(0));
        check("async_mask",      512'(ch_last_mask), 512'(0));
        check("async_rdata",     512'(up_rdata),     512'(0));
        check("async_wack",      512'(up_wack),      512'(0));
        repeat (2) @(negedge up_clk);
        up_resetn = 1'b1;
        @(negedge up_clk);
        check("release_sw_resetn", 512'(ch_sw_resetn), 512'(4'hF));
        repeat (2) @(negedge up_clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
